// File: rtl/mfp_eic_prio_pkg.sv
// Shared types and constants for the MIPSfpga+ EIC priority arbiter.
// State encodings, blank length and the clog2 helper.
package mfp_eic_prio;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    BLANK = 2'd2
  } state_e;

  localparam logic [1:0] BLANK_CYCLES = 2'd2;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/mfp_eic_prio_enc.sv
// Combinational highest-index encoder with detect.
// Parametrised on vector width N and index width W.
module mfp_eic_prio_enc #(
  parameter int N = 64,
  parameter int W = 6
) (
  input  logic [N-1:0] vec,
  output logic         detect,
  output logic [W-1:0] index
);

  always_comb begin
    detect = 1'b0;
    index  = '0;
    for (int i = 0; i < N; i++) begin
      if (vec[i]) begin
        detect = 1'b1;
        index  = W'(i);
      end
    end
  end

endmodule

// File: rtl/mfp_eic_prio_arbiter.sv
// Registered priority arbiter with valid/ack grant handshake.
// Round-robin support is built only with MFP_EIC_PRIO_RR_EN defined.
module mfp_eic_prio_arbiter
  import mfp_eic_prio::*;
#(
  parameter  int N = 64,
  localparam int W = clog2(N)
) (
  input  logic         CLK,
  input  logic         RESETn,
  input  logic [N-1:0] in,
  input  logic [N-1:0] mask,
  input  logic         mode,
  output logic         out_valid,
  output logic [W-1:0] out_index,
  input  logic         out_ack
);

  state_e         state_q, state_d;
  logic [N-1:0]   s1_q, s1_d;
  logic [W-1:0]   idx_q, idx_d;
  logic [1:0]     blank_q, blank_d;
  logic [W-1:0]   ptr;
  logic [W:0]     sh;
  logic [2*N-1:0] dbl;
  logic [N-1:0]   rot;
  logic           det;
  logic [W-1:0]   enc_idx;
  logic [W-1:0]   idx;

`ifdef MFP_EIC_PRIO_RR_EN
  logic [W-1:0] p_q, p_d;

  assign ptr = mode ? p_q : '1;

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) p_q <= '1;
    else         p_q <= p_d;
  end
`else
  logic unused_mode;

  assign unused_mode = mode;
  assign ptr         = '1;
`endif

  // Rotate so line ptr sits at the top, encode, then rotate back.
  assign sh  = {1'b0, ptr} + (W+1)'(1);
  assign dbl = {s1_q, s1_q} >> sh;
  assign rot = dbl[N-1:0];
  assign idx = enc_idx + sh[W-1:0];

  mfp_eic_prio_enc #(
    .N(N),
    .W(W)
  ) u_enc (
    .vec   (rot),
    .detect(det),
    .index (enc_idx)
  );

  assign s1_d      = in & mask;
  assign out_valid = (state_q == GRANT);
  assign out_index = idx_q;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    blank_d = blank_q;
`ifdef MFP_EIC_PRIO_RR_EN
    p_d     = p_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (det) begin
          idx_d   = idx;
          state_d = GRANT;
        end
      end
      GRANT: begin
        if (out_ack) begin
          state_d = BLANK;
          blank_d = BLANK_CYCLES;
`ifdef MFP_EIC_PRIO_RR_EN
          if (mode) p_d = idx_q - W'(1);
`endif
        end else if (!s1_q[idx_q]) begin
          state_d = IDLE;
        end
      end
      BLANK: begin
        blank_d = blank_q - 2'd1;
        if (blank_q == 2'd1) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      state_q <= IDLE;
      s1_q    <= '0;
      idx_q   <= '0;
      blank_q <= '0;
    end else begin
      state_q <= state_d;
      s1_q    <= s1_d;
      idx_q   <= idx_d;
      blank_q <= blank_d;
    end
  end

endmodule

// File: tb/tb_mfp_eic_prio_arbiter.sv
// Self-checking bench for mfp_eic_prio_arbiter (N = 64).
// Directed scenarios plus random traffic against a behavioural model.
module tb_mfp_eic_prio_arbiter;

  localparam int N = 64;

`ifdef MFP_EIC_PRIO_RR_EN
  localparam bit RR_EN = 1'b1;
`else
  localparam bit RR_EN = 1'b0;
`endif

  logic         CLK;
  logic         RESETn;
  logic [N-1:0] in_v;
  logic [N-1:0] mask_v;
  logic         mode;
  logic         out_valid;
  logic [5:0]   out_index;
  logic         out_ack;

  int checks;
  int failures;

  bit [N-1:0] m_s1;
  bit         m_busy;
  int         m_blank;
  int         m_grant;
  int         m_ptr;

  mfp_eic_prio_arbiter #(.N(N)) dut (
    .CLK      (CLK),
    .RESETn   (RESETn),
    .in       (in_v),
    .mask     (mask_v),
    .mode     (mode),
    .out_valid(out_valid),
    .out_index(out_index),
    .out_ack  (out_ack)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp,
               $time);
    end
  endtask

  function automatic int pick(input bit [N-1:0] v, input int p);
    for (int k = 0; k < N; k++) begin
      int i;
      i = (p - k + N) % N;
      if (v[i]) return i;
    end
    return -1;
  endfunction

  task automatic m_reset();
    m_s1    = '0;
    m_busy  = 1'b0;
    m_blank = 0;
    m_grant = 0;
    m_ptr   = N - 1;
  endtask

  task automatic m_edge();
    int w;
    bit rr;
    rr = RR_EN && (mode == 1'b1);
    if (!RESETn) begin
      m_reset();
    end else begin
      if (m_busy) begin
        if (out_ack) begin
          m_busy  = 1'b0;
          m_blank = 2;
          if (rr) m_ptr = (m_grant + N - 1) % N;
        end else if (!m_s1[m_grant]) begin
          m_busy = 1'b0;
        end
      end else if (m_blank > 0) begin
        m_blank--;
      end else begin
        w = pick(m_s1, rr ? m_ptr : N - 1);
        if (w >= 0) begin
          m_busy  = 1'b1;
          m_grant = w;
        end
      end
      m_s1 = in_v & mask_v;
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    m_edge();
    #1;
    chk("valid", out_valid, m_busy);
    if (m_busy) chk("index", out_index, m_grant);
  endtask

  task automatic do_reset();
    RESETn = 1'b0;
    m_reset();
    #1;
    chk("rst_valid", out_valid, 0);
    chk("rst_index", out_index, 0);
    tick();
    RESETn = 1'b1;
  endtask

  task automatic set_bits(input int a, input int b, input int c);
    in_v = '0;
    if (a >= 0) in_v[a] = 1'b1;
    if (b >= 0) in_v[b] = 1'b1;
    if (c >= 0) in_v[c] = 1'b1;
  endtask

  int exp_rr[4];
  int got_q[$];

  initial begin
    checks   = 0;
    failures = 0;
    RESETn   = 1'b0;
    in_v     = '1;
    mask_v   = '1;
    mode     = 1'b0;
    out_ack  = 1'b0;
    m_reset();

    // reset held with all lines pending
    #1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_hold_index", out_index, 0);
    end
    RESETn = 1'b1;
    tick();
    chk("first_not_yet", out_valid, 0);
    tick();
    chk("first_valid", out_valid, 1);
    chk("first_index", out_index, 63);

    // fixed priority, ack and blank window
    do_reset();
    set_bits(3, 40, -1);
    tick();
    tick();
    chk("fix_40", out_index, 40);
    tick();
    chk("fix_hold", out_index, 40);
    out_ack = 1'b1;
    tick();
    chk("fix_ack_low", out_valid, 0);
    out_ack = 1'b0;
    in_v[40] = 1'b0;
    tick();
    chk("blank1", out_valid, 0);
    tick();
    chk("blank2", out_valid, 0);
    tick();
    chk("fix_next_v", out_valid, 1);
    chk("fix_next_3", out_index, 3);

    // masking, unmasking during grant
    do_reset();
    set_bits(63, 5, -1);
    mask_v = '1;
    mask_v[63] = 1'b0;
    tick();
    tick();
    chk("mask_5", out_index, 5);
    mask_v = '1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("mask_hold", out_index, 5);
    end
    out_ack = 1'b1;
    tick();
    out_ack = 1'b0;
    for (int i = 0; i < 4; i++) tick();

    // round-robin sequence with immediate acks
    do_reset();
    mode = 1'b1;
    set_bits(10, 20, 30);
    out_ack = 1'b1;
    if (RR_EN) exp_rr = '{30, 20, 10, 30};
    else       exp_rr = '{30, 30, 30, 30};
    got_q.delete();
    for (int i = 0; i < 40 && got_q.size() < 4; i++) begin
      tick();
      if (out_valid) got_q.push_back(int'(out_index));
    end
    chk("rr_count", got_q.size(), 4);
    for (int i = 0; i < 4 && i < got_q.size(); i++)
      chk($sformatf("rr_seq%0d", i), got_q[i], exp_rr[i]);
    out_ack = 1'b0;
    mode = 1'b0;

    // retraction leaves the pointer alone
    do_reset();
    set_bits(7, -1, -1);
    tick();
    tick();
    chk("retr_7", out_index, 7);
    in_v = '0;
    tick();
    chk("retr_still", out_valid, 1);
    tick();
    chk("retr_fall", out_valid, 0);
    tick();
    chk("retr_quiet", out_valid, 0);
    mode = 1'b1;
    set_bits(3, 50, -1);
    tick();
    tick();
    chk("retr_ptr", out_index, 50);

    // move the pointer, then reset mid-grant
    out_ack = 1'b1;
    tick();
    out_ack = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    chk("rr_after", out_index, RR_EN ? 3 : 50);
    #2;
    RESETn = 1'b0;
    m_reset();
    #1;
    chk("midrst_valid", out_valid, 0);
    tick();
    RESETn = 1'b1;
    set_bits(10, 60, -1);
    tick();
    tick();
    chk("midrst_ptr", out_index, 60);

    // random traffic
    for (int c = 0; c < 600; c++) begin
      if (c % 6 == 0) begin
        for (int b = 0; b < N; b++) in_v[b] = ($urandom_range(0, 15) == 0);
        for (int b = 0; b < N; b++) mask_v[b] = ($urandom_range(0, 7) != 0);
      end
      if ($urandom_range(0, 19) == 0) mode = ~mode;
      out_ack = ($urandom_range(0, 2) == 0);
      if (c == 300) begin
        RESETn = 1'b0;
        m_reset();
        #1;
        chk("rnd_rst", out_valid, 0);
      end
      if (c == 302) RESETn = 1'b1;
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
